// File: rtl/clk_mon_poller.sv
`default_nettype none
// ============================================================================
// clk_mon_poller : AXI4-Lite read master that sweeps the clk_mon registers,
//                  snapshots them and range-checks each word.
// Optional macro : CLK_MON_POLL_TIMEOUT_EN (handshake timeout + timeout port)
// Revision       : 1.0  initial release
// ============================================================================
module clk_mon_poller #(
   parameter int unsigned NUM_REGS       = 4,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int unsigned POLL_PERIOD    = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic                     enable,
   input  logic [31:0]              lo_thresh,
   input  logic [31:0]              hi_thresh,
   output logic [31:0]              m_axi_araddr,
   output logic [2:0]               m_axi_arprot,
   output logic                     m_axi_arvalid,
   input  logic                     m_axi_arready,
   input  logic [31:0]              m_axi_rdata,
   input  logic [1:0]               m_axi_rresp,
   input  logic                     m_axi_rvalid,
   output logic                     m_axi_rready,
   output logic [32*NUM_REGS-1:0]   snapshot,
   output logic [NUM_REGS-1:0]      alarm,
   output logic                     sweep_done,
   output logic                     resp_err
`ifdef CLK_MON_POLL_TIMEOUT_EN
   ,
   output logic                     timeout
`endif
);

   localparam int unsigned IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [31:0] PERIOD_RELOAD = 32'(POLL_PERIOD - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_AR   = 3'd2,
      ST_R    = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [31:0]               cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [31:0]               araddr_q, araddr_d;
   logic [32*NUM_REGS-1:0]    snap_q, snap_d;
   logic [NUM_REGS-1:0]       alarm_q, alarm_d;
   logic                      resp_err_q, resp_err_d;
   logic                      word_bad;
   logic                      to_hit;
   logic                      abort;

`ifdef CLK_MON_POLL_TIMEOUT_EN
   localparam int unsigned TO_W        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_q, timeout_d;

   assign to_hit  = (to_cnt_q == TO_LAST);
   assign timeout = timeout_q;

   // Counter restarts on every state entry, so it measures one handshake wait.
   always_comb begin
      to_cnt_d  = '0;
      timeout_d = timeout_q;
      if (((state_q == ST_AR) || (state_q == ST_R)) && (state_d == state_q))
         to_cnt_d = to_cnt_q + 1'b1;
      if ((state_q == ST_IDLE) && !enable)
         timeout_d = 1'b0;
      else if (abort)
         timeout_d = 1'b1;
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   assign abort    = to_hit && (((state_q == ST_AR) && !m_axi_arready) ||
                                ((state_q == ST_R)  && !m_axi_rvalid));
   assign word_bad = (m_axi_rdata < lo_thresh) || (m_axi_rdata > hi_thresh) ||
                     (m_axi_rresp != 2'b00);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      araddr_d   = araddr_q;
      snap_d     = snap_q;
      alarm_d    = alarm_q;
      resp_err_d = resp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (!enable) begin
               resp_err_d = 1'b0;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = PERIOD_RELOAD;
            end
         end
         ST_WAIT: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 32'd0) begin
               state_d  = ST_AR;
               idx_d    = '0;
               araddr_d = BASE_ADDR;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         ST_AR: begin
            if (m_axi_arready) begin
               state_d = ST_R;
            end else if (abort) begin
               state_d        = ST_IDLE;
               alarm_d[idx_q] = 1'b1;
            end
         end
         ST_R: begin
            if (m_axi_rvalid) begin
               snap_d[32*idx_q +: 32] = m_axi_rdata;
               alarm_d[idx_q]         = word_bad;
               if (m_axi_rresp != 2'b00)
                  resp_err_d = 1'b1;
               // A late disable lets the in-flight read finish, then stops quietly.
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_AR;
                  idx_d    = idx_q + 1'b1;
                  araddr_d = araddr_q + 32'd4;
               end
            end else if (abort) begin
               state_d        = ST_IDLE;
               alarm_d[idx_q] = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_WAIT;
            cnt_d   = PERIOD_RELOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         araddr_q   <= '0;
         snap_q     <= '0;
         alarm_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         araddr_q   <= araddr_d;
         snap_q     <= snap_d;
         alarm_q    <= alarm_d;
         resp_err_q <= resp_err_d;
      end
   end

   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = (state_q == ST_AR);
   assign m_axi_rready  = (state_q == ST_R);
   assign sweep_done    = (state_q == ST_DONE);
   assign snapshot      = snap_q;
   assign alarm         = alarm_q;
   assign resp_err      = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_mon_poller.sv
`default_nettype none
// ============================================================================
// tb_clk_mon_poller : scoreboard bench with a behavioural AXI4-Lite slave.
// Revision          : 1.0  initial release
// ============================================================================
module tb_clk_mon_poller;

   localparam int          NR     = 4;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          PERIOD = 5;

   logic            ACLK;
   logic            ARESETN;
   logic            enable;
   logic [31:0]     lo_thresh, hi_thresh;
   logic [31:0]     m_axi_araddr;
   logic [2:0]      m_axi_arprot;
   logic            m_axi_arvalid, m_axi_arready;
   logic [31:0]     m_axi_rdata;
   logic [1:0]      m_axi_rresp;
   logic            m_axi_rvalid, m_axi_rready;
   logic [32*NR-1:0] snapshot;
   logic [NR-1:0]   alarm;
   logic            sweep_done, resp_err;

   clk_mon_poller #(
      .NUM_REGS       (NR),
      .BASE_ADDR      (BASE),
      .POLL_PERIOD    (PERIOD),
      .TIMEOUT_CYCLES (256)
   ) u_dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .enable        (enable),
      .lo_thresh     (lo_thresh),
      .hi_thresh     (hi_thresh),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .snapshot      (snapshot),
      .alarm         (alarm),
      .sweep_done    (sweep_done),
      .resp_err      (resp_err)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   logic [31:0]      regs [NR];
   logic [1:0]       resp [NR];
   int               ar_delay = 0;
   int               r_delay  = 0;
   int               ar_count = 0;
   logic [31:0]      exp_addr_q [$];
   logic [32*NR-1:0] exp_snap_q [$];
   logic [NR-1:0]    exp_alarm_q [$];
   logic [32*NR-1:0] last_snap;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_regs(input logic [31:0] r0, r1, r2, r3);
      regs[0] = r0; regs[1] = r1; regs[2] = r2; regs[3] = r3;
      for (int i = 0; i < NR; i++) resp[i] = 2'b00;
   endtask

   // Expected addresses always; expected snapshot/alarm only for a full sweep.
   task automatic push_sweep(input int n_words, input bit full);
      logic [32*NR-1:0] s;
      logic [NR-1:0]    a;
      s = last_snap;
      a = '0;
      for (int i = 0; i < n_words; i++) begin
         exp_addr_q.push_back(BASE + 32'(4 * i));
         s[32*i +: 32] = regs[i];
         a[i] = (regs[i] < lo_thresh) || (regs[i] > hi_thresh) || (resp[i] != 2'b00);
      end
      last_snap = s;
      if (full) begin
         exp_snap_q.push_back(s);
         exp_alarm_q.push_back(a);
      end
   endtask

   task automatic run_sweep(input bit chk_lat, input bit keep);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      enable = 1'b1;
      while (!seen && n < 1000) begin
         @(negedge ACLK);
         n++;
         seen = sweep_done;
      end
      chk("done_seen", seen, 1'b1);
      if (chk_lat) chk("latency", n, 1 + PERIOD + 2 * NR);
      if (!keep) begin
         enable = 1'b0;
         repeat (4) @(negedge ACLK);
         chk("idle_after", {m_axi_arvalid, m_axi_rready, sweep_done}, 3'b000);
         chk("addr_q_empty", exp_addr_q.size(), 0);
      end
   endtask

   // Behavioural slave: AR then R, with programmable stalls.
   initial begin : slave
      logic [31:0] a;
      int w;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      forever begin
         @(negedge ACLK);
         if (m_axi_arvalid) begin
            a = m_axi_araddr;
            for (int k = 0; k < ar_delay; k++) begin
               @(negedge ACLK);
               chk("ar_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, a});
            end
            m_axi_arready = 1'b1;
            @(posedge ACLK);
            #1 m_axi_arready = 1'b0;
            ar_count++;
            chk("ar_expected", exp_addr_q.size() != 0, 1'b1);
            if (exp_addr_q.size() != 0) chk("araddr", a, exp_addr_q.pop_front());
            @(negedge ACLK);
            chk("ar_drop", {m_axi_arvalid, m_axi_rready}, 2'b01);
            for (int k = 0; k < r_delay; k++) begin
               @(negedge ACLK);
               chk("r_wait", {m_axi_arvalid, m_axi_rready}, 2'b01);
            end
            w = int'((a - BASE) >> 2);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = (w < NR) ? regs[w] : 32'hDEAD_BEEF;
            m_axi_rresp  = (w < NR) ? resp[w] : 2'b00;
            @(posedge ACLK);
            #1;
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = '0;
            m_axi_rresp  = 2'b00;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge ACLK);
         if (sweep_done) begin
            chk("done_expected", exp_snap_q.size() != 0, 1'b1);
            if (exp_snap_q.size() != 0) begin
               chk("snapshot", snapshot, exp_snap_q.pop_front());
               chk("alarm", alarm, exp_alarm_q.pop_front());
            end
            @(negedge ACLK);
            chk("done_pulse", sweep_done, 1'b0);
         end
      end
   end

   initial begin : main
      int  n;
      bit  found;
      int  ar_before;
      ARESETN   = 1'b0;
      enable    = 1'b0;
      lo_thresh = '0;
      hi_thresh = '0;
      last_snap = '0;
      set_regs(32'd0, 32'd0, 32'd0, 32'd0);
      repeat (3) @(negedge ACLK);
      chk("rst_araddr", m_axi_araddr, 32'h0);
      chk("rst_arprot", m_axi_arprot, 3'b000);
      chk("rst_valid", {m_axi_arvalid, m_axi_rready}, 2'b00);
      chk("rst_snapshot", snapshot, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_flags", {sweep_done, resp_err}, 2'b00);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);
      chk("idle_no_enable", {m_axi_arvalid, m_axi_rready, sweep_done}, 3'b000);

      // In-range sweep
      set_regs(32'd1, 32'd2, 32'd3, 32'd4);
      lo_thresh = 32'd0; hi_thresh = 32'd10;
      push_sweep(NR, 1'b1);
      run_sweep(1'b1, 1'b0);

      // Range check with a narrow window
      lo_thresh = 32'd2; hi_thresh = 32'd3;
      push_sweep(NR, 1'b1);
      run_sweep(1'b1, 1'b0);

      // Inverted thresholds: everything alarms
      set_regs(32'd0, 32'd5, 32'hFFFF_FFFF, 32'd7);
      lo_thresh = 32'd10; hi_thresh = 32'd1;
      push_sweep(NR, 1'b1);
      run_sweep(1'b1, 1'b0);

      // Back-pressure on both channels
      set_regs(32'hA, 32'hB, 32'hC, 32'hD);
      lo_thresh = 32'd0; hi_thresh = 32'hC;
      ar_delay = 7; r_delay = 5;
      push_sweep(NR, 1'b1);
      run_sweep(1'b0, 1'b0);
      ar_delay = 0; r_delay = 0;
      chk("ar_count", ar_count, 4 * NR);

      // SLVERR on word 2; resp_err survives a clean sweep, clears on disable
      set_regs(32'd1, 32'd2, 32'd3, 32'd4);
      lo_thresh = 32'd0; hi_thresh = 32'd10;
      resp[2] = 2'b10;
      push_sweep(NR, 1'b1);
      run_sweep(1'b1, 1'b1);
      chk("resp_err_set", resp_err, 1'b1);
      resp[2] = 2'b00;
      push_sweep(NR, 1'b1);
      run_sweep(1'b0, 1'b1);
      chk("resp_err_sticky", resp_err, 1'b1);
      enable = 1'b0;
      repeat (4) @(negedge ACLK);
      chk("resp_err_clear", resp_err, 1'b0);
      chk("snapshot_hold", snapshot, last_snap);

      // Disable while word 1's read is outstanding
      set_regs(32'd5, 32'd6, 32'd7, 32'd8);
      r_delay = 3;
      ar_before = ar_count;
      push_sweep(2, 1'b0);
      enable = 1'b1;
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         @(negedge ACLK);
         n++;
         found = m_axi_rready && (m_axi_araddr == BASE + 32'd4);
      end
      chk("reached_r1", found, 1'b1);
      enable = 1'b0;
      repeat (12) @(negedge ACLK);
      r_delay = 0;
      chk("disable_idle", {m_axi_arvalid, m_axi_rready, sweep_done}, 3'b000);
      chk("disable_ar_count", ar_count, ar_before + 2);
      chk("disable_addr_q", exp_addr_q.size(), 0);
      chk("disable_snapshot", snapshot, last_snap);

      // Asynchronous reset during an address phase
      exp_addr_q.push_back(BASE);
      enable = 1'b1;
      found = 1'b0;
      n = 0;
      while (!found && n < 50) begin
         @(negedge ACLK);
         n++;
         found = m_axi_arvalid;
      end
      chk("reached_ar", found, 1'b1);
      #2 ARESETN = 1'b0;
      #1;
      chk("async_rst_valid", {m_axi_arvalid, m_axi_rready, sweep_done}, 3'b000);
      chk("async_rst_snapshot", snapshot, 0);
      chk("async_rst_araddr", m_axi_araddr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
